// File: rtl/exec_control_pkg.sv
// ---------------------------------------------------------------------------
// exec_control_pkg
//   Shared types and helpers for the run/step/halt execution controller.
//   - state_e   : FSM state encoding (IDLE=0, RUN=1, STEP=2, HALTED=3)
//   - STATE_W   : width of the state encoding
//   - btn_ev_t  : one-cycle press events from the three debounced buttons
//   - cnt_w()   : debounce counter width for a given DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
package exec_control_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic halt;
    logic run;
    logic step;
  } btn_ev_t;

  // The counter only has to reach n-1, so clog2(n) bits suffice; keep at
  // least one bit so the smallest legal window (n=2) still has a counter.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Execution is enabled only while running or taking a single step.
  function automatic logic exec_en(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/exec_control_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push-button: 2-flop synchroniser, stability counter,
//   debounced level and rising-edge detect.
//   Parameters:
//     DEBOUNCE_CYCLES : consecutive stable cycles before the level flips (>=2)
//   Ports:
//     clk      : system clock
//     reset_n  : asynchronous active-low reset
//     btn_i    : raw asynchronous button, active-high
//     press_o  : one-cycle pulse on each debounced rising edge
// ---------------------------------------------------------------------------
module btn_debounce
  import exec_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;      // sync_q[1] is the synchronised button
  logic          deb_q, deb_d;
  logic          deb_dly_q;   // previous debounced level for edge detect
  logic [CW-1:0] cnt_q, cnt_d;

  // Count while the synchronised input disagrees with the debounced level;
  // any agreement (a bounce back) clears the count, restarting the window.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q[1];
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  // Combinational from two flops: the press is seen by the FSM on the same
  // edge after the level flips, keeping press-to-enable at D+3 edges.
  assign press_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/exec_control.sv
// ---------------------------------------------------------------------------
// exec_control
//   Run/step/halt controller gating the core's execution enable from the
//   board push-buttons, with a saturating enabled-cycle counter for debug.
//   Build option: define EXEC_CTRL_STEP_EN to enable the single-step button
//   and the STEP state; otherwise btn_step is ignored and STEP is unreachable.
//   Parameters:
//     DEBOUNCE_CYCLES : debounce window in cycles (>=2)
//     COUNT_W         : width of exec_cycles
//   Ports:
//     clk, reset_n     : clock, asynchronous active-low reset
//     btn_run/step/halt: raw asynchronous buttons, active-high
//     cpu_halt         : synchronous halt level from the core
//     enable_execution : core clock-enable (RUN or STEP)
//     state            : current FSM state
//     exec_cycles      : saturating count of enabled cycles
// ---------------------------------------------------------------------------
module exec_control
  import exec_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_run,
  input  logic               btn_step,
  input  logic               btn_halt,
  input  logic               cpu_halt,
  output logic               enable_execution,
  output logic [STATE_W-1:0] state,
  output logic [COUNT_W-1:0] exec_cycles
);

  logic    run_press, halt_press, step_press;
  btn_ev_t ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_run),
    .press_o (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_halt),
    .press_o (halt_press)
  );

`ifdef EXEC_CTRL_STEP_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_step),
    .press_o (step_press)
  );
`else
  logic unused_btn_step;
  assign unused_btn_step = btn_step;
  assign step_press      = 1'b0;
`endif

  assign ev = '{halt: halt_press, run: run_press, step: step_press};

  // ---------------- FSM ----------------
  state_e             state_q, state_d;
  logic               en_q;
  logic [COUNT_W-1:0] cyc_q;

  // Priority halt (button or core) > run > step wherever they compete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if      (ev.run)  state_d = ST_RUN;
        else if (ev.step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (ev.halt || cpu_halt) state_d = ST_HALTED;
      end
      // Single enabled cycle; presses arriving now are dropped.
      ST_STEP: state_d = cpu_halt ? ST_HALTED : ST_IDLE;
      ST_HALTED: begin
        // A core that is still asserting halt pins us here.
        if (!cpu_halt && !ev.halt) begin
          if      (ev.run)  state_d = ST_RUN;
          else if (ev.step) state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enable is registered from the next state so it is a clean flop output
  // that always equals the decode of state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= exec_en(state_d);
      if (en_q && !(&cyc_q)) cyc_q <= cyc_q + COUNT_W'(1);
    end
  end

  assign enable_execution = en_q;
  assign state            = state_q;
  assign exec_cycles      = cyc_q;

endmodule
